// File: rtl/fmap_stream_out.sv
// Unloads the conv2 output feature map: captures it on start and streams it
// out as WORD_W-bit words over valid/ready. Optional header word: FMAP_HDR_EN.
module fmap_stream_out #(
  parameter int H      = 4,
  parameter int W      = 4,
  parameter int C      = 60,
  parameter int WORD_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [H*W*C-1:0]    fmap_in,
  output logic [WORD_W-1:0]   m_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic                m_last,
  output logic                busy,
  output logic                done
);

  localparam int MAP_W = H * W * C;
  localparam int WPP   = (C + WORD_W - 1) / WORD_W;
  localparam int N     = H * W * WPP;
`ifdef FMAP_HDR_EN
  localparam int HOFS  = 1;
  localparam logic [WORD_W-1:0] HDR = WORD_W'(16'({C[7:0], H[3:0], W[3:0]}));

  generate
    if (WORD_W < 16) begin : g_hdr_width_check
      $error("fmap_stream_out: header requires WORD_W >= 16");
    end
  endgenerate
`else
  localparam int HOFS  = 0;
`endif
  localparam int NT    = N + HOFS;
  localparam int CW    = $clog2(NT + 1);
  localparam logic [CW-1:0] LAST    = CW'(NT - 1);
  localparam logic [CW-1:0] PRELAST = CW'(NT - 2);

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  state_t            state;
  logic [MAP_W-1:0]  shadow;
  logic [CW-1:0]     idx;

  // Data word d: pixel d/WPP, chunk d%WPP; channels past C read as 0.
  function automatic logic [WORD_W-1:0] word_of(input logic [MAP_W-1:0] map,
                                                 input int unsigned d);
    int unsigned p, k, c;
    logic [WORD_W-1:0] w;
    p = d / WPP;
    k = d % WPP;
    w = '0;
    for (int unsigned i = 0; i < WORD_W; i++) begin
      c = k * WORD_W + i;
      if (c < C) w[i] = map[p * C + c];
    end
    return w;
  endfunction

  function automatic logic [WORD_W-1:0] frame_word(input logic [MAP_W-1:0] map,
                                                   input int unsigned seq);
`ifdef FMAP_HDR_EN
    if (seq == 0) return HDR;
    return word_of(map, seq - 1);
`else
    return word_of(map, seq);
`endif
  endfunction

  // Outputs are registered: the next word is prepared on the accepting edge,
  // so m_data/m_last only move on a handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      shadow  <= '0;
      idx     <= '0;
      m_data  <= '0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            shadow  <= fmap_in;
            idx     <= '0;
            m_data  <= frame_word(fmap_in, 0);
            m_valid <= 1'b1;
            m_last  <= (NT == 1);
            busy    <= 1'b1;
            state   <= STREAM;
          end
        end
        STREAM: begin
          if (m_ready) begin
            if (idx == LAST) begin
              m_data  <= '0;
              m_valid <= 1'b0;
              m_last  <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
              state   <= DONE;
            end else begin
              idx    <= idx + 1'b1;
              m_data <= frame_word(shadow, int'(idx) + 1);
              m_last <= (idx == PRELAST);
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fmap_stream_out.sv
// Directed bench for fmap_stream_out; follows FMAP_HDR_EN when defined.
module tb_fmap_stream_out;

  localparam int H    = 4;
  localparam int W    = 4;
  localparam int C    = 60;
  localparam int MAPW = H * W * C;
  localparam int N    = 64;
`ifdef FMAP_HDR_EN
  localparam int HOFS = 1;
`else
  localparam int HOFS = 0;
`endif
  localparam int NT   = N + HOFS;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            m_ready = 1'b0;
  logic [MAPW-1:0] fmap_in = '0;
  logic [MAPW-1:0] alt = '0;
  logic [15:0]     m_data;
  logic            m_valid, m_last, busy, done;

  int total = 0;
  int bad   = 0;

  logic [15:0] got[$];
  logic        lasts[$];
  int first_cyc, last_cyc, done_cyc, unstable, busy_bad;
  bit timeout, busy_at_done;

  fmap_stream_out #(.H(H), .W(W), .C(C), .WORD_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .fmap_in(fmap_in),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_last(m_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] exp_word(input logic [MAPW-1:0] map, input int d);
    logic [15:0] w;
    int p, k;
    w = '0;
    p = d / 4;
    k = d % 4;
    for (int i = 0; i < 16; i++)
      if (k * 16 + i < C) w[i] = map[p * C + k * 16 + i];
    return w;
  endfunction

  task automatic pulse_start(input logic [MAPW-1:0] map);
    @(negedge clk);
    fmap_in = map;
    start = 1'b1;
    @(negedge clk);
  endtask

  // Gathers accepted words starting at the negedge after capture. pattern 0:
  // ready always high; 1: ready 1,0,0,1 repeating. Optional restart/stop points.
  task automatic collect(input int pattern, input int restart_at, input int stop_at,
                         input int budget);
    logic [15:0] pd;
    logic pl, rdy;
    bit pend, restarted;
    got.delete(); lasts.delete();
    first_cyc = -1; last_cyc = -1; done_cyc = -1;
    unstable = 0; busy_bad = 0; timeout = 1; busy_at_done = 1;
    pend = 0; restarted = 0; pd = '0; pl = 1'b0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      if (pend && (m_valid !== 1'b1 || m_data !== pd || m_last !== pl)) unstable++;
      if (m_valid === 1'b1 && busy !== 1'b1) busy_bad++;
      start = 1'b0;
      if (done === 1'b1) begin
        done_cyc = cyc; busy_at_done = busy; timeout = 0;
        break;
      end
      if (got.size() == stop_at) begin
        timeout = 0;
        break;
      end
      if (got.size() == restart_at && !restarted) begin
        start = 1'b1; fmap_in = alt; restarted = 1;
      end
      rdy = (pattern == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      m_ready = rdy;
      if (m_valid === 1'b1 && rdy) begin
        got.push_back(m_data);
        lasts.push_back(m_last);
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        pend = 0;
      end else begin
        pend = (m_valid === 1'b1);
        pd = m_data;
        pl = m_last;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; m_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if ({m_valid, busy, done, m_last, m_data} !== 20'h0) begin
        bad++;
        $display("FAIL reset_idle cyc=%0d: valid=%b busy=%b done=%b last=%b data=%h, want all 0",
                 i, m_valid, busy, done, m_last, m_data);
      end
    end
  endtask

  task automatic test_full_drain();
    logic [MAPW-1:0] m;
    int nz, nl;
    m = '0;
    m[(1 * W + 2) * C + 17] = 1'b1;
    pulse_start(m);
    collect(0, -1, -1, 200);
    total++;
    if (timeout || got.size() != NT) begin
      bad++; $display("FAIL drain_count: got %0d words timeout=%0d, want %0d", got.size(), timeout, NT);
    end
    total++;
    if (first_cyc != 0 || last_cyc - first_cyc != NT - 1) begin
      bad++; $display("FAIL drain_timing: first=%0d last=%0d, want 0 and %0d", first_cyc, last_cyc, NT - 1);
    end
    total++;
    if (done_cyc != last_cyc + 1 || busy_at_done !== 1'b0) begin
      bad++; $display("FAIL drain_done: done_cyc=%0d busy=%b, want %0d and 0", done_cyc, busy_at_done, last_cyc + 1);
    end
    total++;
    if (busy_bad != 0) begin
      bad++; $display("FAIL drain_busy: %0d valid cycles without busy, want 0", busy_bad);
    end
    if (got.size() == NT) begin
      total++;
      if (got[HOFS + 25] !== 16'h0002) begin
        bad++; $display("FAIL drain_word25: got %h, want 0002", got[HOFS + 25]);
      end
      nz = 0; nl = 0;
      for (int d = 0; d < N; d++) if (d != 25 && got[HOFS + d] !== 16'h0) nz++;
      for (int d = 0; d < NT; d++) if (lasts[d] === 1'b1) nl++;
      total++;
      if (nz != 0) begin
        bad++; $display("FAIL drain_zero_words: %0d nonzero words, want 0", nz);
      end
      total++;
      if (nl != 1 || lasts[NT - 1] !== 1'b1) begin
        bad++; $display("FAIL drain_last: %0d last flags, final=%b, want 1 on final", nl, lasts[NT - 1]);
      end
    end
  endtask

  task automatic test_padding();
    logic [15:0] want;
    pulse_start('1);
    collect(0, -1, -1, 200);
    total++;
    if (timeout || got.size() != NT) begin
      bad++; $display("FAIL pad_count: got %0d words, want %0d", got.size(), NT);
    end
    if (got.size() == NT) begin
      for (int d = 0; d < N; d++) begin
        want = (d % 4 == 3) ? 16'h0FFF : 16'hFFFF;
        total++;
        if (got[HOFS + d] !== want) begin
          bad++; $display("FAIL pad_word%0d: got %h, want %h", d, got[HOFS + d], want);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [MAPW-1:0] m;
    int nbad;
    for (int j = 0; j < MAPW; j++) m[j] = (j % 3 == 0) ^ (j % 7 == 0);
    pulse_start(m);
    collect(1, -1, -1, 400);
    total++;
    if (timeout || got.size() != NT) begin
      bad++; $display("FAIL bp_count: got %0d handshakes timeout=%0d, want %0d", got.size(), timeout, NT);
    end
    total++;
    if (unstable != 0) begin
      bad++; $display("FAIL bp_stable: %0d unstable stalled cycles, want 0", unstable);
    end
    if (got.size() == NT) begin
      nbad = 0;
      for (int d = 0; d < N; d++) if (got[HOFS + d] !== exp_word(m, d)) nbad++;
      total++;
      if (nbad != 0) begin
        bad++; $display("FAIL bp_data: %0d words differ, want 0", nbad);
      end
      total++;
      if (lasts[NT - 1] !== 1'b1 || lasts[NT - 2] !== 1'b0) begin
        bad++; $display("FAIL bp_last: last flags %b%b, want 01", lasts[NT - 2], lasts[NT - 1]);
      end
    end
  endtask

  // Entered right after the done pulse: start held from the DONE cycle on.
  task automatic test_back_to_back();
    logic [MAPW-1:0] m;
    m = '0;
    m[(1 * W + 2) * C + 17] = 1'b1;
    fmap_in = m;
    start = 1'b1;
    @(negedge clk);
    total++;
    if (m_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL b2b_ignore: valid=%b busy=%b done=%b, want 0 0 0", m_valid, busy, done);
    end
    @(negedge clk);
    collect(0, -1, -1, 200);
    total++;
    if (timeout || got.size() != NT || first_cyc != 0) begin
      bad++; $display("FAIL b2b_frame: words=%0d first=%0d, want %0d and 0", got.size(), first_cyc, NT);
    end
    if (got.size() == NT) begin
      total++;
      if (got[HOFS + 25] !== 16'h0002) begin
        bad++; $display("FAIL b2b_word25: got %h, want 0002", got[HOFS + 25]);
      end
    end
  endtask

  task automatic test_restart_abort();
    logic [MAPW-1:0] m;
    int nbad;
    m = '0;
    m[(1 * W + 2) * C + 17] = 1'b1;
    alt = '1;
    pulse_start(m);
    collect(0, 10, 30, 200);
    total++;
    if (timeout || got.size() != 30) begin
      bad++; $display("FAIL restart_count: got %0d words, want 30", got.size());
    end
    if (got.size() == 30) begin
      nbad = 0;
      for (int s = HOFS; s < 30; s++)
        if (got[s] !== ((s - HOFS == 25) ? 16'h0002 : 16'h0000)) nbad++;
      total++;
      if (nbad != 0) begin
        bad++; $display("FAIL restart_ignored: %0d words not from original capture, want 0", nbad);
      end
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (m_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || m_last !== 1'b0) begin
      bad++; $display("FAIL abort_now: valid=%b busy=%b done=%b last=%b, want 0", m_valid, busy, done, m_last);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (done !== 1'b0 || m_valid !== 1'b0) begin
        bad++; $display("FAIL abort_nodone cyc=%0d: done=%b valid=%b, want 0 0", i, done, m_valid);
      end
    end
    pulse_start(m);
    collect(0, -1, -1, 200);
    total++;
    if (timeout || got.size() != NT || first_cyc != 0) begin
      bad++; $display("FAIL abort_refill: words=%0d first=%0d, want %0d and 0", got.size(), first_cyc, NT);
    end
    if (got.size() == NT) begin
      total++;
      if (got[HOFS + 25] !== 16'h0002 || got[HOFS] !== 16'h0000) begin
        bad++; $display("FAIL abort_refill_data: w0=%h w25=%h, want 0000 0002", got[HOFS], got[HOFS + 25]);
      end
    end
  endtask

`ifdef FMAP_HDR_EN
  task automatic test_header();
    int nz, nl;
    pulse_start('0);
    collect(0, -1, -1, 200);
    total++;
    if (timeout || got.size() != N + 1) begin
      bad++; $display("FAIL hdr_count: got %0d words, want %0d", got.size(), N + 1);
    end
    if (got.size() == N + 1) begin
      total++;
      if (got[0] !== 16'h3C44) begin
        bad++; $display("FAIL hdr_word: got %h, want 3c44", got[0]);
      end
      nz = 0; nl = 0;
      for (int s = 1; s <= N; s++) if (got[s] !== 16'h0) nz++;
      for (int s = 0; s <= N; s++) if (lasts[s] === 1'b1) nl++;
      total++;
      if (nz != 0 || nl != 1 || lasts[N] !== 1'b1) begin
        bad++; $display("FAIL hdr_body: nonzero=%0d lasts=%0d final=%b, want 0 1 1", nz, nl, lasts[N]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_full_drain();
    test_padding();
    test_backpressure();
    test_back_to_back();
    test_restart_abort();
`ifdef FMAP_HDR_EN
    test_header();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fmap_stream_out.md
Name: fmap_stream_out

Overview:
- Output-side unloader for the conv2 engine.
- Captures the parallel binary feature map (out_fmap2, 4x4x60 bits) when the engine asserts its done flag.
- Streams the captured map out as fixed-width words over a valid/ready interface to the host/readback path.
- Performs the reverse of the file-to-array loading done on the input side: array to word stream.

Parameters:
H, 4, feature map rows
W, 4, feature map columns
C, 60, channels per pixel
WORD_W, 16, output word width in bits

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  capture request; connect to conv engine done_conv
fmap_in  input  H*W*C  flattened map; bit (y*W+x)*C+c = out_fmap2[y][x][c]
m_data  output  WORD_W  stream data word
m_valid  output  1  m_data valid
m_ready  input  1  downstream accepts word
m_last  output  1  marks final word of frame
busy  output  1  high from capture until final handshake
done  output  1  one-cycle pulse after final handshake

Behaviour:
- Reset (async, rst_n=0): m_valid=0, m_last=0, busy=0, done=0, m_data=0, state=IDLE, counters=0.
- Reset asserted mid-frame aborts the frame; no done pulse; the captured map is discarded.
- Words per pixel WPP = ceil(C/WORD_W); with defaults WPP=4. Frame length N = H*W*WPP; with defaults N=64.
- Word order is y-major, then x, then channel chunk k = 0..WPP-1.
- Word k carries channels c = k*WORD_W + i in bit i.
- Bits where c >= C are driven 0; with defaults, the last chunk has bits [15:12]=0.
- States:
  - IDLE: start=1 sampled at a rising edge loads fmap_in into an internal shadow register, sets busy=1, and goes to STREAM. start is a level; sampling happens only in IDLE.
  - STREAM: m_valid=1 from the cycle after capture, so word 0 appears 1 cycle after start.
    - A handshake (m_valid & m_ready) advances the word counter.
    - m_last=1 exactly while word N-1 is presented.
    - Handshake on word N-1 goes to DONE.
  - DONE: done=1 and busy=0 for one cycle, m_valid=0, then go to IDLE.
- Back-to-back words: with m_ready held high, one word is transferred per cycle.
- Stability: while m_valid=1 and m_ready=0, m_data and m_last are held constant. m_valid never drops before its handshake.
- start while busy or in DONE is ignored. The shadow register is not overwritten mid-frame, so fmap_in may change freely after the capture edge.
- start asserted in the same cycle as the DONE→IDLE transition is ignored. start sampled in IDLE on the next edge captures a new frame.
- The counter never wraps mid-frame. The word index is clog2(N+1) bits wide.
- m_ready while m_valid=0 has no effect.
- Minimum frame time is N+2 cycles from start to done.

Optional Feature:
FMAP_HDR_EN
- Defined: a header word precedes the data words.
  - Header layout: bits [3:0]=W, [7:4]=H, [15:8]=C[7:0]; upper bits are 0.
  - Requires WORD_W>=16; elaboration fails otherwise.
  - Header is presented 1 cycle after start.
  - Frame length becomes N+1; m_last still marks the final data word.
  - With defaults the header value is 16'h3C44.
- Undefined: no header; the frame is exactly N data words as above.

Test Plan:
- Reset/idle: rst_n=0 then 1, start=0 for 10 cycles -> m_valid=0, busy=0, done=0, m_data=0 throughout.
- Full drain: fmap_in with only bit (y=1,x=2,c=17) set, m_ready=1, start pulse -> 64 words in 64 consecutive cycles; only word index 25 = 16'h0002; m_last on word 63; done pulse on the following cycle.
- Padding: fmap_in all ones -> words with k=0..2 = 16'hFFFF and k=3 = 16'h0FFF for every pixel.
- Backpressure: m_ready toggles 1,0,0,1 repeating -> m_data/m_last stable during low-ready cycles, no word dropped or duplicated, exactly 64 handshakes.
- Ignored start plus mid-frame reset: start re-pulsed at word 10 with different fmap_in -> stream continues from original capture. Then rst_n=0 at word 30 -> immediate m_valid=0, busy=0, no done. Next start yields a full 64-word frame from word 0.
- FMAP_HDR_EN defined: start with all-zero fmap_in -> first word 16'h3C44, then 64 zero words, m_last on the 65th word.
